// File: rtl/fsm_spi_pkg.sv
// Shared types and default constants for the fsm_spi transmit-only SPI master.
// Holds the FSM state encoding plus default frame width and SCLK divider.
package fsm_spi_pkg;

  localparam int DATA_WIDTH = 12;
  localparam int CLK_DIV    = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    END  = 2'd2
  } spi_state_t;

endpackage

// File: rtl/fsm_spi_sclk_gen.sv
// Free-running SCLK divider: sclk toggles every CLK_DIV clk cycles.
// Ports: clk, rst (sync, active low) in; sclk, fall_evt, rise_evt out.
module spi_sclk_gen #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  output logic sclk,
  output logic fall_evt,
  output logic rise_evt
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] div_cnt;
  logic          wrap;

  assign wrap = (div_cnt == CW'(CLK_DIV - 1));

  // Strobes mark the cycle whose closing edge moves sclk,
  // so registered consumers update on the same edge.
  assign fall_evt = wrap & sclk;
  assign rise_evt = wrap & ~sclk;

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fsm_spi.sv
// Transmit-only SPI master (mode 0): sends TX_DATA LSB first while tx_enable.
// Ports: clk, rst (sync, active low), tx_enable in; mosi, cs, sclk out.
module fsm_spi #(
  parameter int DATA_WIDTH = fsm_spi_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] TX_DATA = 12'hACE,
  parameter int CLK_DIV = fsm_spi_pkg::CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic tx_enable,
  output logic mosi,
  output logic cs,
  output logic sclk
);

  import fsm_spi_pkg::*;

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int PW = 1 << CW;

  // Word padded to a power of two so bit_cnt indexes it exactly.
  localparam logic [PW-1:0] TX_PAD = PW'(TX_DATA);

  spi_state_t    state;
  logic [CW-1:0] bit_cnt;
  logic          fall_evt;
  logic          rise_evt;

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .fall_evt (fall_evt),
    .rise_evt (rise_evt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cs      <= 1'b1;
      mosi    <= 1'b0;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fall_evt && tx_enable) begin
            state   <= SEND;
            cs      <= 1'b0;
            mosi    <= TX_PAD[0];
            bit_cnt <= CW'(1);
          end
        end
        SEND: begin
          if (fall_evt) begin
            if (bit_cnt < CW'(DATA_WIDTH)) begin
              mosi    <= TX_PAD[bit_cnt];
              bit_cnt <= bit_cnt + 1'b1;
            end else begin
              state   <= END;
              cs      <= 1'b1;
              mosi    <= 1'b0;
              bit_cnt <= '0;
            end
          end
        end
        END: begin
          if (fall_evt) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          cs      <= 1'b1;
          mosi    <= 1'b0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  // The divider can never flag both edges in one cycle.
  a_edges_exclusive: assert property (
    @(posedge clk) disable iff (!rst)
    !(fall_evt && rise_evt)
  );

endmodule

// File: tb/tb_fsm_spi.sv
// Directed bench for fsm_spi: reset, divider, frames, gap, drop, abort.
// Drives clk/rst/tx_enable; samples outputs 1ns after each rising edge.
module tb_fsm_spi;

  logic clk = 1'b0;
  logic rst;
  logic tx_enable;
  logic mosi;
  logic cs;
  logic sclk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bit exp_seq [12] = '{0, 1, 1, 1, 0, 0, 1, 1, 0, 1, 0, 1};

  fsm_spi dut (
    .clk       (clk),
    .rst       (rst),
    .tx_enable (tx_enable),
    .mosi      (mosi),
    .cs        (cs),
    .sclk      (sclk)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_cs_low(input string tag);
    int n = 0;
    while (cs !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_cs_low_timeout"}, int'(cs), 0);
  endtask

  task automatic wait_edge(input bit rising, input string tag);
    int  n = 0;
    bit  seen = 0;
    logic prev = sclk;
    while (!seen && n < 100) begin
      tick();
      n++;
      seen = rising ? (prev == 1'b0 && sclk == 1'b1)
                    : (prev == 1'b1 && sclk == 1'b0);
      prev = sclk;
    end
    if (!seen) check({tag, "_edge_timeout"}, 0, 1);
  endtask

  task automatic run_frame(input int drop_at, input string tag);
    wait_cs_low(tag);
    check({tag, "_start_sclk"}, int'(sclk), 0);
    for (int i = 0; i < 12; i++) begin
      wait_edge(1'b1, tag);
      check($sformatf("%s_bit%0d", tag, i), int'(mosi), int'(exp_seq[i]));
      check($sformatf("%s_cs%0d", tag, i), int'(cs), 0);
      if (i == drop_at - 1) tx_enable = 1'b0;
    end
    wait_edge(1'b0, tag);
    check({tag, "_end_cs"}, int'(cs), 1);
    check({tag, "_end_mosi"}, int'(mosi), 0);
  endtask

  task automatic hold_idle(input int n, input string tag);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (cs !== 1'b1 || mosi !== 1'b0) bad++;
    end
    check({tag, "_idle_glitches"}, bad, 0);
  endtask

  initial begin
    int gap;
    rst       = 1'b0;
    tx_enable = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("rst_sclk%0d", i), int'(sclk), 0);
      check($sformatf("rst_cs%0d", i), int'(cs), 1);
      check($sformatf("rst_mosi%0d", i), int'(mosi), 0);
    end
    rst = 1'b1;
    cyc = 0;

    for (int k = 1; k <= 60; k++) begin
      tick();
      check($sformatf("div_sclk%0d", k), int'(sclk), (k / 10) % 2);
      check($sformatf("div_cs%0d", k), int'(cs), 1);
      check($sformatf("div_mosi%0d", k), int'(mosi), 0);
    end

    tx_enable = 1'b1;
    wait_cs_low("f1");
    check("f1_start_cyc", cyc, 80);
    run_frame(-1, "f1");

    gap = 0;
    while (cs === 1'b1 && gap < 200) begin
      tick();
      gap++;
    end
    check("gap_clks", gap, 40);
    run_frame(-1, "f2");

    run_frame(4, "drop");
    hold_idle(120, "drop");

    tx_enable = 1'b1;
    wait_cs_low("ab");
    for (int i = 0; i < 6; i++) wait_edge(1'b1, "ab");
    check("ab_pre_cs", int'(cs), 0);
    rst       = 1'b0;
    tx_enable = 1'b0;
    tick();
    check("ab_cs", int'(cs), 1);
    check("ab_mosi", int'(mosi), 0);
    check("ab_sclk", int'(sclk), 0);
    tick();
    rst = 1'b1;
    cyc = 0;
    hold_idle(80, "ab_post");
    tx_enable = 1'b1;
    wait_cs_low("f3");
    check("f3_start_cyc", cyc, 100);
    run_frame(-1, "f3");
    tx_enable = 1'b0;
    hold_idle(60, "final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
